// File: rtl/tx_frame_queue_pkg.sv
// Shared types for the transmit frame queue: frame width and scheduler state encodings.
// The state values are fixed so a future receive-side queue can reuse them.
package tx_frame_queue_pkg;

  localparam int FRAME_SIZE = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } tx_state_t;

endpackage

// File: rtl/frame_fifo.sv
// Synchronous FIFO holding frames for the transmit scheduler.
// Pointers wrap naturally (DEPTH is a power of two); count disambiguates full from empty.
module frame_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Fullness is judged on the registered count, so a pop never frees room for a same-cycle push.
  assign full    = (count == FULL_COUNT);
  assign do_push = push && !full;
  assign do_pop  = pop && (count != '0);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/tx_frame_queue.sv
// Buffers host frames and feeds them one at a time to the transceiver, holding each until
// irq_tx acknowledges it or the timeout drops it, with an enforced idle gap between frames.
module tx_frame_queue
  import tx_frame_queue_pkg::*;
#(
  parameter int DEPTH          = 8,
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [FRAME_SIZE-1:0]  in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   irq_tx,
  output logic [FRAME_SIZE-1:0]  tx_data,
  output logic                   tx_enable,
  output logic [$clog2(DEPTH):0] count,
  output logic                   sent,
  output logic                   tx_timeout
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LAST   = GW'(GAP_CYCLES - 1);

  tx_state_t             state_q;
  tx_state_t             state_d;
  logic [TW-1:0]         timer_q;
  logic [GW-1:0]         gap_q;
  logic [FRAME_SIZE-1:0] head;
  logic                  full;
  logic                  load;
  logic                  pop;
  logic                  ack;
  logic                  drop;

  assign in_ready = !full;

  frame_fifo #(
    .WIDTH (FRAME_SIZE),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (in_valid),
    .push_data (in_data),
    .pop       (pop),
    .head      (head),
    .count     (count),
    .full      (full)
  );

  // GAP waits for irq_tx to fall so a lingering ack cannot complete the following frame.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    pop     = 1'b0;
    ack     = 1'b0;
    drop    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (count != '0 && !irq_tx) begin
          load    = 1'b1;
          state_d = SEND;
        end
      end
      SEND: begin
        if (irq_tx) begin
          pop     = 1'b1;
          ack     = 1'b1;
          state_d = GAP;
        end else if (timer_q == TIMER_LAST) begin
          pop     = 1'b1;
          drop    = 1'b1;
          state_d = GAP;
        end
      end
      GAP: begin
        if (gap_q == GAP_LAST && !irq_tx) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      tx_data    <= '0;
      tx_enable  <= 1'b0;
      sent       <= 1'b0;
      tx_timeout <= 1'b0;
      timer_q    <= '0;
      gap_q      <= '0;
    end else begin
      state_q    <= state_d;
      sent       <= ack;
      tx_timeout <= drop;
      if (load) begin
        tx_data   <= head;
        tx_enable <= 1'b1;
        timer_q   <= '0;
      end else if (pop) begin
        tx_enable <= 1'b0;
        gap_q     <= '0;
      end else if (state_q == SEND) begin
        timer_q <= timer_q + 1'b1;
      end else if (state_q == GAP && gap_q != GAP_LAST) begin
        gap_q <= gap_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_tx_frame_queue.sv
// Randomised and directed bench for tx_frame_queue against a transaction-level queue model.
module tb_tx_frame_queue;
  import tx_frame_queue_pkg::*;

  localparam int DEPTH = 8;
  localparam int GAP   = 2;
  localparam int TMO   = 16;

  logic                  clock = 1'b0;
  logic                  reset = 1'b0;
  logic [FRAME_SIZE-1:0] in_data = '0;
  logic                  in_valid = 1'b0;
  logic                  irq_tx = 1'b0;
  logic                  in_ready;
  logic [FRAME_SIZE-1:0] tx_data;
  logic                  tx_enable;
  logic [3:0]            count;
  logic                  sent;
  logic                  tx_timeout;

  int n_cmp = 0;
  int n_bad = 0;

  tx_frame_queue #(
    .DEPTH          (DEPTH),
    .GAP_CYCLES     (GAP),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .irq_tx     (irq_tx),
    .tx_data    (tx_data),
    .tx_enable  (tx_enable),
    .count      (count),
    .sent       (sent),
    .tx_timeout (tx_timeout)
  );

  always #5 clock = ~clock;

  // Reference: a queue of frames plus "how long has the current frame been on the wire"
  // and "may a new frame start yet" bookkeeping.
  logic [FRAME_SIZE-1:0] mq[$];
  bit                    m_sending;
  int                    m_held;
  int                    m_since;
  bit                    m_armed;
  logic [FRAME_SIZE-1:0] m_data;
  bit                    m_sent;
  bit                    m_to;

  int sent_seen = 0;
  int to_seen   = 0;
  int en_seen   = 0;
  int en_run    = 0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_sending = 0;
    m_held    = 0;
    m_since   = 0;
    m_armed   = 1;
    m_data    = '0;
    m_sent    = 0;
    m_to      = 0;
  endtask

  task automatic model_edge();
    bit can_take;
    bit finish;
    can_take = (mq.size() < DEPTH);
    finish   = 0;
    m_sent   = 0;
    m_to     = 0;
    if (m_sending) begin
      if (irq_tx) begin
        m_sent = 1;
        finish = 1;
      end else if (m_held == TMO) begin
        m_to   = 1;
        finish = 1;
      end else begin
        m_held++;
      end
    end else begin
      m_since++;
      if (!m_armed) begin
        if (m_since >= GAP && !irq_tx) m_armed = 1;
      end else if (mq.size() != 0 && !irq_tx) begin
        m_sending = 1;
        m_held    = 1;
        m_data    = mq[0];
      end
    end
    if (finish) begin
      void'(mq.pop_front());
      m_sending = 0;
      m_armed   = 0;
      m_since   = 0;
    end
    if (in_valid && can_take) mq.push_back(in_data);
  endtask

  task automatic compare_all();
    checkOutput("tx_enable", {31'd0, tx_enable}, {31'd0, m_sending});
    checkOutput("tx_data", {16'd0, tx_data}, {16'd0, m_data});
    checkOutput("count", {28'd0, count}, mq.size());
    checkOutput("in_ready", {31'd0, in_ready}, {31'd0, mq.size() != DEPTH});
    checkOutput("sent", {31'd0, sent}, {31'd0, m_sent});
    checkOutput("tx_timeout", {31'd0, tx_timeout}, {31'd0, m_to});
  endtask

  task automatic tick();
    model_edge();
    @(posedge clock);
    #1;
    compare_all();
    if (sent) sent_seen++;
    if (tx_timeout) to_seen++;
    if (tx_enable) en_seen++;
    en_run = tx_enable ? en_run + 1 : 0;
  endtask

  task automatic applyStimulus(input logic v, input logic [FRAME_SIZE-1:0] d, input logic irq);
    in_valid = v;
    in_data  = d;
    irq_tx   = irq;
    tick();
  endtask

  task automatic wait_enable(input string tag, input int limit);
    for (int i = 0; i < limit && !tx_enable; i++) applyStimulus(1'b0, '0, 1'b0);
    checkOutput(tag, {31'd0, tx_enable}, 32'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 400 && (mq.size() != 0 || m_sending); i++)
      applyStimulus(1'b0, '0, tx_enable && !irq_tx);
    for (int i = 0; i < GAP + 2; i++) applyStimulus(1'b0, '0, 1'b0);
    checkOutput("drain_empty", {28'd0, count}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base;
    model_reset();
    #2;
    compare_all();
    #10 reset = 1'b1;

    // Single frame acknowledged after ten idle cycles.
    base = sent_seen;
    applyStimulus(1'b1, 16'h5045, 1'b0);
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, '0, 1'b0);
    checkOutput("single_data", {16'd0, tx_data}, 32'h5045);
    applyStimulus(1'b0, '0, 1'b1);
    applyStimulus(1'b0, '0, 1'b0);
    checkOutput("single_sent", sent_seen - base, 32'd1);
    drain();

    // Burst of three frames, acked by a transceiver-like responder.
    base = sent_seen;
    applyStimulus(1'b1, 16'h5045, 1'b0);
    applyStimulus(1'b1, 16'h5452, 1'b0);
    applyStimulus(1'b1, 16'h4121, 1'b0);
    for (int i = 0; i < 40; i++) applyStimulus(1'b0, '0, tx_enable && en_run >= 2);
    checkOutput("burst_sent", sent_seen - base, 32'd3);
    drain();

    // Fill the queue with the transceiver silent.
    for (int i = 0; i <= DEPTH; i++) applyStimulus(1'b1, 16'(16'h1000 + i), 1'b0);
    checkOutput("full_count", {28'd0, count}, DEPTH);
    checkOutput("full_ready", {31'd0, in_ready}, 32'd0);
    drain();

    // Timeout drops the first frame; the second one follows.
    base    = to_seen;
    en_seen = 0;
    applyStimulus(1'b1, 16'hAAAA, 1'b0);
    applyStimulus(1'b1, 16'h1234, 1'b0);
    for (int i = 0; i < 17; i++) applyStimulus(1'b0, '0, 1'b0);
    checkOutput("timeout_pulses", to_seen - base, 32'd1);
    checkOutput("timeout_enable_cycles", en_seen, TMO);
    wait_enable("timeout_next_frame", 6);
    checkOutput("timeout_next_data", {16'd0, tx_data}, 32'h1234);
    drain();

    // Acknowledge held high: the next frame must wait for it to fall.
    applyStimulus(1'b1, 16'h0C0C, 1'b0);
    applyStimulus(1'b1, 16'h0D0D, 1'b0);
    wait_enable("sticky_first", 4);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b0, '0, 1'b1);
      checkOutput("sticky_hold", {31'd0, tx_enable}, 32'd0);
    end
    wait_enable("sticky_resume", 6);
    checkOutput("sticky_data", {16'd0, tx_data}, 32'h0D0D);
    drain();

    // Random traffic.
    for (int i = 0; i < 1500; i++)
      applyStimulus(1'($urandom_range(0, 1)), 16'($urandom), $urandom_range(0, 3) == 0);
    drain();

    // Asynchronous reset while a frame is on the wire.
    applyStimulus(1'b1, 16'hBEEF, 1'b0);
    applyStimulus(1'b1, 16'hCAFE, 1'b0);
    wait_enable("reset_wait_enable", 5);
    reset = 1'b0;
    #1;
    model_reset();
    compare_all();
    #2 reset = 1'b1;
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, '0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/tx_frame_queue.md
# tx_frame_queue

Frame buffer and transmit scheduler sitting directly upstream of `transceiver`. Accepts `FRAME_SIZE`-bit frames from the host over a valid/ready handshake, stores them in a FIFO, and presents them one at a time to the transceiver by driving its `data_in`/`tx_enable`. Each frame is held until the transceiver raises `irq_tx`. An inter-frame gap and a per-frame timeout keep a stalled optical link from hanging the host.

## Interface
- `FRAME_SIZE`, `` `FRAME_SIZE `` (16): frame width, taken from `definitions.v`.
- `DEPTH`, 8: FIFO entries; power of two, ≥2.
- `GAP_CYCLES`, 2: minimum idle cycles between `tx_enable` deassert and the next assert; ≥1.
- `TIMEOUT_CYCLES`, 4096: maximum cycles `tx_enable` is held waiting for `irq_tx`; ≥2.

Ports:
- `clock`  in  1  single clock, all state on rising edge.
- `reset`  in  1  asynchronous, active-low reset (asserted when 0).
- `in_data`  in  FRAME_SIZE  frame from host.
- `in_valid`  in  1  `in_data` valid.
- `in_ready`  out  1  queue can accept; equals not-full.
- `irq_tx`  in  1  transceiver transmit-done, level, from `transceiver.irq_tx`.
- `tx_data`  out  FRAME_SIZE  to `transceiver.data_in`.
- `tx_enable`  out  1  to `transceiver.tx_enable`.
- `count`  out  log2(DEPTH)+1  frames stored, including the one in flight.
- `sent`  out  1  one-cycle pulse: frame acknowledged by `irq_tx`.
- `tx_timeout`  out  1  one-cycle pulse: frame dropped on timeout.

## Operation
- Reset values: `in_ready`=1, `tx_enable`=0, `tx_data`=0, `count`=0, `sent`=0, `tx_timeout`=0, FSM=IDLE, FIFO empty.
- Write: `in_valid && in_ready` at an edge stores `in_data` and increments `count`.
  - `in_ready` is strictly `count != DEPTH`. A same-cycle pop does not free space for that cycle's push.
- FSM states IDLE, SEND, GAP:
  - IDLE: when `count != 0` and `irq_tx == 0`, load `tx_data` with the FIFO head, set `tx_enable`=1, clear the timeout counter, go to SEND.
  - SEND: `tx_data` and `tx_enable` are held stable.
    - If `irq_tx`=1: pop the head, `tx_enable`=0, pulse `sent`, go to GAP.
    - Otherwise, if the timeout counter = TIMEOUT_CYCLES-1: pop (drop) the head, `tx_enable`=0, pulse `tx_timeout`, go to GAP.
    - `irq_tx` has priority over timeout in the same cycle.
  - GAP: count GAP_CYCLES cycles. Leave for IDLE only when the count is done and `irq_tx`=0. Otherwise stay, so a lingering `irq_tx` is never mistaken for the next frame's acknowledgement.
- `tx_data` keeps the last frame after deassert; it changes only on IDLE→SEND.
- Simultaneous push and pop: `count` unchanged, both take effect.
- FIFO pointers wrap modulo DEPTH. `count` distinguishes full from empty.
- Reset mid-frame: `tx_enable` drops to 0 asynchronously and all queued frames are discarded.

## Timing
- Accept into an empty queue at edge k, with FSM in IDLE and `irq_tx`=0: `tx_enable`=1 and `tx_data` valid after edge k+1.
- `irq_tx` sampled high at edge m: `tx_enable`=0, `sent`=1, `count` decremented after edge m. `sent` clears after m+1.
- Back-to-back frames: the next `tx_enable` rises no earlier than GAP_CYCLES+1 edges after the deassert edge.
- Timeout: `tx_enable` high for exactly TIMEOUT_CYCLES cycles, then `tx_timeout` pulses for one cycle.
- `in_ready` updates the cycle after the write or pop that changes `count`.

## Structure
- `FRAME_SIZE` stays in the shared `definitions.v`. Add the FSM state encodings (IDLE/SEND/GAP) there as `` `define `` constants for reuse by a future receive-side queue.
- Sub-module `frame_fifo`: synchronous FIFO with DEPTH/width parameters, push/pop/head/count, and async active-low reset.
  - `tx_frame_queue` wraps it with the FSM, gap counter and timeout counter.

## Test plan
- Single frame: push 16'h5045, hold `irq_tx`=0 for 10 cycles then 1.
  - Expect `tx_enable` high one cycle after the accept, `tx_data`=16'h5045 throughout, one `sent` pulse, `count` 1→0.
- Burst: push 16'h5045, 16'h5452, 16'h4121 back-to-back, with `irq_tx` modelled as a transceiver ack.
  - Expect frames transmitted in that order and ≥GAP_CYCLES idle cycles between enables.
- Full: push DEPTH+1 frames with `irq_tx` stuck at 0.
  - Expect `in_ready`=0 after DEPTH accepts, `count`=DEPTH, and the extra frame not stored.
- Timeout: with TIMEOUT_CYCLES=16, push 16'hAAAA and never raise `irq_tx`.
  - Expect `tx_enable` high for 16 cycles, one `tx_timeout` pulse, the frame dropped, and the next frame sent.
- Sticky ack: hold `irq_tx`=1 for 5 cycles after the ack.
  - Expect the FSM to stay in GAP and the next `tx_enable` only after `irq_tx` falls.
- Reset mid-SEND: drive `reset`=0 while `tx_enable`=1.
  - Expect `tx_enable`=0 immediately, `count`=0, `in_ready`=1.
